// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - two-requester round-robin arbiter driving one mode-0 SPI master port
module spi_master_arbiter #(
    parameter int DW      = 8,
    parameter int CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    input  logic [2*DW-1:0] req_data,
    output logic [1:0]      req_ready,
    output logic [1:0]      rsp_valid,
    output logic [DW-1:0]   rsp_data,
    output logic            busy,
    output logic            m_sck_o,
    output logic            m_sck_t,
    output logic            m_io0_o,
    output logic            m_io0_t,
    input  logic            m_io1_i,
    output logic            m_ss_o,
    output logic            m_ss1_o,
    output logic            m_ss_t
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_TOP  = BW'(DW - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          done_q, done_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;
    logic [DW-1:0] sh_q, sh_d;
    logic [DW-1:0] rx_q, rx_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic          ss0_q, ss0_d;
    logic          ss1_q, ss1_d;
    logic [1:0]    ready_q, ready_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          tri_q;

    logic          cnt_wrap;
    logic [CW-1:0] cnt_inc;
    logic          gsel;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        done_d   = done_q;
        sel_d    = sel_q;
        last_d   = last_q;
        sh_d     = sh_q;
        rx_d     = rx_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        ss0_d    = ss0_q;
        ss1_d    = ss1_q;
        ready_d  = 2'b00;
        rvalid_d = 2'b00;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        cnt_wrap = (cnt_q == DIV_LAST);
        cnt_inc  = cnt_wrap ? '0 : cnt_q + 1'b1;
        // On a tie the requester that did not win last time is served.
        gsel     = (req_valid == 2'b11) ? ~last_q : req_valid[1];

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                busy_d = 1'b0;
                if (req_valid != 2'b00) begin
                    sel_d   = gsel;
                    last_d  = gsel;
                    ready_d = gsel ? 2'b10 : 2'b01;
                    sh_d    = gsel ? req_data[DW +: DW] : req_data[0 +: DW];
                    bit_d   = BIT_TOP;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                ss0_d  = sel_q;
                ss1_d  = ~sel_q;
                sck_d  = 1'b0;
                mosi_d = sh_q[DW-1];
                cnt_d  = cnt_inc;
                if (cnt_wrap) state_d = SHIFT;
            end
            SHIFT: begin
                cnt_d = cnt_inc;
                if (cnt_q == '0) begin
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        rx_d = {rx_q[DW-2:0], m_io1_i};
                    end else begin
                        sh_d   = {sh_q[DW-2:0], 1'b0};
                        mosi_d = sh_q[DW-2];
                        if (bit_q == '0) done_d = 1'b1;
                        else             bit_d  = bit_q - 1'b1;
                    end
                end
                // Leave once the final falling edge has completed its low half-period.
                if (cnt_wrap && (done_q || (cnt_q == '0 && sck_q && bit_q == '0)))
                    state_d = HOLD;
            end
            HOLD: begin
                cnt_d = cnt_inc;
                if (cnt_wrap) state_d = GAP;
            end
            GAP: begin
                if (cnt_q == '0) begin
                    ss0_d    = 1'b1;
                    ss1_d    = 1'b1;
                    mosi_d   = 1'b0;
                    rvalid_d = sel_q ? 2'b10 : 2'b01;
                    rdata_d  = rx_q;
                end
                cnt_d = cnt_inc;
                if (cnt_wrap) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            done_q   <= 1'b0;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            sh_q     <= '0;
            rx_q     <= '0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            ss0_q    <= 1'b1;
            ss1_q    <= 1'b1;
            ready_q  <= 2'b00;
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            tri_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            done_q   <= done_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            sh_q     <= sh_d;
            rx_q     <= rx_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            ss0_q    <= ss0_d;
            ss1_q    <= ss1_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            tri_q    <= 1'b0;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rvalid_q;
    assign rsp_data  = rdata_q;
    assign busy      = busy_q;
    assign m_sck_o   = sck_q;
    assign m_io0_o   = mosi_q;
    assign m_ss_o    = ss0_q;
    assign m_ss1_o   = ss1_q;
    assign m_sck_t   = tri_q;
    assign m_io0_t   = tri_q;
    assign m_ss_t    = tri_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - self-checking bench for spi_master_arbiter
module tb_spi_master_arbiter;

    localparam int A_DW     = 8;
    localparam int A_CD     = 2;
    localparam int T_SS_END = (2*A_DW+2)*A_CD;
    localparam int T_RSP    = T_SS_END + 1;
    localparam int T_END    = (2*A_DW+3)*A_CD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // DUT A: DW=8, CLK_DIV=2
    logic [1:0]  a_rv = 2'b00;
    logic [7:0]  a_d0 = 8'h00, a_d1 = 8'h00;
    logic [15:0] a_data;
    logic [1:0]  a_ready, a_rsp_valid;
    logic [7:0]  a_rsp_data;
    logic        a_busy, a_sck, a_sck_t, a_mosi, a_mosi_t, a_miso, a_ss0, a_ss1, a_ss_t;
    logic        drv_loop = 1'b1;
    logic [7:0]  drv_slave = 8'h00;
    assign a_data = {a_d1, a_d0};

    spi_master_arbiter #(.DW(A_DW), .CLK_DIV(A_CD)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_rv), .req_data(a_data),
        .req_ready(a_ready), .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .busy(a_busy),
        .m_sck_o(a_sck), .m_sck_t(a_sck_t), .m_io0_o(a_mosi), .m_io0_t(a_mosi_t),
        .m_io1_i(a_miso), .m_ss_o(a_ss0), .m_ss1_o(a_ss1), .m_ss_t(a_ss_t)
    );

    // DUT B: DW=2, CLK_DIV=1, MISO looped to MOSI
    logic [1:0] b_rv = 2'b00;
    logic [1:0] b_d0 = 2'b00;
    logic [3:0] b_data;
    logic [1:0] b_ready, b_rsp_valid, b_rsp_data;
    logic       b_busy, b_sck, b_sck_t, b_mosi, b_mosi_t, b_ss0, b_ss1, b_ss_t;
    assign b_data = {2'b00, b_d0};

    spi_master_arbiter #(.DW(2), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_rv), .req_data(b_data),
        .req_ready(b_ready), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .busy(b_busy),
        .m_sck_o(b_sck), .m_sck_t(b_sck_t), .m_io0_o(b_mosi), .m_io0_t(b_mosi_t),
        .m_io1_i(b_mosi), .m_ss_o(b_ss0), .m_ss1_o(b_ss1), .m_ss_t(b_ss_t)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Inputs as seen by the DUT at each rising edge
    int         cyc = 0;
    logic       rst_e = 1'b1, loop_e = 1'b1;
    logic [1:0] rv_e = 2'b00;
    logic [7:0] d0_e = 8'h00, d1_e = 8'h00, slave_e = 8'h00;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_e   <= rst;
        rv_e    <= a_rv;
        d0_e    <= a_d0;
        d1_e    <= a_d1;
        loop_e  <= drv_loop;
        slave_e <= drv_slave;
    end

    // Mode-0 slave: presents MSB when selected, shifts on SCK falling edges
    logic [7:0] slave_cur = 8'h00, slave_sh = 8'h00;
    logic       slave_miso = 1'b0;
    logic       m_loop = 1'b1;
    always @(negedge a_ss0 or negedge a_ss1) begin
        slave_sh   = slave_cur;
        slave_miso = slave_cur[7];
    end
    always @(negedge a_sck) begin
        slave_sh   = {slave_sh[6:0], 1'b0};
        slave_miso = slave_sh[7];
    end
    assign a_miso = m_loop ? a_mosi : slave_miso;

    // Reference model: outputs as a function of cycles elapsed since the grant
    logic       m_active = 1'b0, m_last = 1'b1, m_sel = 1'b0;
    int         m_g = 0, t = 0, rises = 0;
    logic [7:0] m_data = 8'h00, m_rx = 8'h00, m_rdata = 8'h00;
    logic [1:0] e_ready, e_rsp, oh;
    logic       e_busy, e_sck, e_ss0, e_ss1, e_t, e_mosi, mosi_chk, sck_prev = 1'b0;

    always @(negedge clk) begin
        e_ready = 2'b00; e_rsp = 2'b00; e_busy = 1'b0; e_sck = 1'b0;
        e_ss0 = 1'b1; e_ss1 = 1'b1; e_t = 1'b0; e_mosi = 1'b0; mosi_chk = 1'b0;
        if (rst_e) begin
            m_active = 1'b0; m_last = 1'b1; m_rdata = 8'h00; e_t = 1'b1;
        end else begin
            if (!m_active && rv_e != 2'b00) begin
                m_sel     = (rv_e == 2'b11) ? ~m_last : rv_e[1];
                m_last    = m_sel;
                m_g       = cyc;
                m_data    = m_sel ? d1_e : d0_e;
                m_loop    = loop_e;
                m_rx      = loop_e ? m_data : slave_e;
                slave_cur = slave_e;
                m_active  = 1'b1;
                rises     = 0;
            end
            if (m_active) begin
                t      = cyc - m_g;
                oh     = m_sel ? 2'b10 : 2'b01;
                e_busy = 1'b1;
                if (t == 0) e_ready = oh;
                if (t >= 1 && t <= T_SS_END) begin e_ss0 = m_sel; e_ss1 = ~m_sel; end
                if (t >= A_CD+1 && t <= (2*A_DW+1)*A_CD) e_sck = (((t - A_CD - 1) / A_CD) % 2) == 0;
                if (t >= 1 && t <= 2*A_DW*A_CD) begin
                    mosi_chk = 1'b1;
                    e_mosi   = m_data[A_DW - 1 - (t - 1) / (2*A_CD)];
                end
                if (a_sck && !sck_prev) rises++;
                if (t == T_RSP) begin
                    e_rsp   = oh;
                    m_rdata = m_rx;
                    chk("sck_rises", rises, A_DW);
                end
                if (t == T_END) m_active = 1'b0;
            end
        end
        chk("outputs", {a_ready, a_rsp_valid, a_busy, a_sck, a_ss0, a_ss1, a_sck_t, a_mosi_t, a_ss_t},
                       {e_ready, e_rsp, e_busy, e_sck, e_ss0, e_ss1, e_t, e_t, e_t});
        chk("rsp_data", a_rsp_data, m_rdata);
        if (mosi_chk) chk("mosi", a_mosi, e_mosi);
        sck_prev = a_sck;
    end

    task automatic wait_ready(output logic [1:0] g);
        int n = 0;
        g = 2'b00;
        while (g == 2'b00 && n < 200) begin @(negedge clk); g = a_ready; n++; end
    endtask

    task automatic wait_rsp(output logic [1:0] v, output logic [7:0] d);
        int n = 0;
        v = 2'b00; d = 8'h00;
        while (v == 2'b00 && n < 200) begin @(negedge clk); v = a_rsp_valid; d = a_rsp_data; n++; end
    endtask

    typedef struct {
        logic [1:0] rv;
        logic [7:0] d0, d1;
        logic       loop;
        logic [7:0] sw;
        logic [1:0] g;
        logic [7:0] rd;
    } vec_t;

    vec_t       tbl[8];
    logic [1:0] g, v;
    logic [7:0] d;
    int         cnt;
    int         b_sck_exp[9] = '{0, 0, 1, 0, 1, 0, 0, 0, 0};
    int         b_ss_exp[9]  = '{1, 0, 0, 0, 0, 0, 0, 1, 1};
    logic [1:0] b_ready_exp, b_rsp_exp;
    logic       b_busy_exp;

    initial begin
        tbl[0] = '{2'b01, 8'hA5, 8'h00, 1'b1, 8'h00, 2'b01, 8'hA5};
        tbl[1] = '{2'b10, 8'h00, 8'hFF, 1'b0, 8'h3C, 2'b10, 8'h3C};
        tbl[2] = '{2'b11, 8'h11, 8'h22, 1'b1, 8'h00, 2'b01, 8'h11};
        tbl[3] = '{2'b11, 8'h11, 8'h22, 1'b1, 8'h00, 2'b10, 8'h22};
        tbl[4] = '{2'b11, 8'h11, 8'h22, 1'b1, 8'h00, 2'b01, 8'h11};
        tbl[5] = '{2'b11, 8'h11, 8'h22, 1'b1, 8'h00, 2'b10, 8'h22};
        tbl[6] = '{2'b01, 8'h5A, 8'h22, 1'b1, 8'h00, 2'b01, 8'h5A};
        tbl[7] = '{2'b01, 8'h00, 8'h22, 1'b0, 8'h81, 2'b01, 8'h81};

        repeat (3) @(negedge clk);
        chk("reset_ss", {a_ss0, a_ss1}, 2'b11);
        chk("reset_rsp_data", a_rsp_data, 8'h00);
        chk("reset_tri", {a_sck_t, a_mosi_t, a_ss_t}, 3'b111);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            a_rv = tbl[i].rv; a_d0 = tbl[i].d0; a_d1 = tbl[i].d1;
            drv_loop = tbl[i].loop; drv_slave = tbl[i].sw;
            wait_ready(g);
            chk($sformatf("row%0d_grant", i), g, tbl[i].g);
            wait_rsp(v, d);
            chk($sformatf("row%0d_rsp_valid", i), v, tbl[i].g);
            chk($sformatf("row%0d_rsp_data", i), d, tbl[i].rd);
        end
        a_rv = 2'b00;
        repeat (10) @(negedge clk);

        // Reset 10 cycles into a transfer, then check last_grant went back to 1
        a_rv = 2'b01; a_d0 = 8'hC3; drv_loop = 1'b1;
        wait_ready(g);
        chk("pre_rst_grant", g, 2'b01);
        repeat (10) @(negedge clk);
        rst = 1'b1; a_rv = 2'b00;
        @(negedge clk);
        chk("rst_abort", {a_ss0, a_ss1, a_sck, a_busy, a_rsp_valid}, 6'b110000);
        rst = 1'b0;
        a_rv = 2'b11; a_d0 = 8'h96; a_d1 = 8'h69;
        wait_ready(g);
        chk("post_rst_grant", g, 2'b01);
        a_rv = 2'b00;
        wait_rsp(v, d);
        chk("post_rst_rsp", {v, d}, {2'b01, 8'h96});
        repeat (10) @(negedge clk);

        // A request raised and dropped while busy never gets a grant
        a_rv = 2'b01; a_d0 = 8'h3C;
        wait_ready(g);
        a_rv = 2'b00;
        repeat (5) @(negedge clk);
        a_rv = 2'b10;
        repeat (5) @(negedge clk);
        a_rv = 2'b00;
        wait_rsp(v, d);
        chk("drop_rsp", {v, d}, {2'b01, 8'h3C});
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_ready != 2'b00 || a_sck || !a_ss0 || !a_ss1) cnt++;
        end
        chk("no_activity_after_drop", cnt, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) a_rv = 2'($urandom);
            a_d0 = 8'($urandom); a_d1 = 8'($urandom);
            drv_loop = 1'($urandom_range(0, 1)); drv_slave = 8'($urandom);
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 1'b0; a_rv = 2'b00;
        repeat (60) @(negedge clk);

        // DW=2, CLK_DIV=1 loopback of 2'b10
        b_rv = 2'b01; b_d0 = 2'b10;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 0) b_rv = 2'b00;
            b_ready_exp = (k == 0) ? 2'b01 : 2'b00;
            b_rsp_exp   = (k == 7) ? 2'b01 : 2'b00;
            b_busy_exp  = (k <= 7);
            chk($sformatf("b_cycle%0d", k), {b_ready, b_rsp_valid, b_busy, b_sck, b_ss0, b_ss1},
                {b_ready_exp, b_rsp_exp, b_busy_exp, 1'(b_sck_exp[k]), 1'(b_ss_exp[k]), 1'b1});
            if (k == 7) chk("b_rsp_data", b_rsp_data, 2'b10);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
